// File: rtl/rs_syndrome_calc.sv
// RS(16,8) syndrome generator over GF(256), primitive polynomial 0x11d.
// Streams one codeword in, highest-degree symbol first, and presents S_0..S_{NSYN-1}.

module gf256mul_dec (
   input  logic [7:0] a_i,
   input  logic [7:0] b_i,
   output logic [7:0] p_o
);
   logic [7:0] aa;

   // Shift-and-add product; each doubling of a is reduced by 0x11d.
   always_comb begin
      p_o = 8'h00;
      aa  = a_i;
      for (int k = 0; k < 8; k++) begin
         if (b_i[k]) p_o = p_o ^ aa;
         aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1d : 8'h00);
      end
   end
endmodule

module rs_syndrome_calc #(
   parameter int N    = 16,
   parameter int NSYN = 8,
   parameter int FCR  = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [7:0]        in_sym,
   output logic              syn_valid,
   input  logic              syn_ready,
   output logic [8*NSYN-1:0] syn_flat,
   output logic              syn_nonzero
);
   localparam int CW = $clog2(N);

   function automatic logic [7:0] alpha_pow(input int e);
      logic [7:0] v;
      v = 8'h01;
      for (int k = 0; k < e; k++) v = {v[6:0], 1'b0} ^ (v[7] ? 8'h1d : 8'h00);
      return v;
   endfunction

   typedef enum logic {ACCUM, HOLD} state_e;

   state_e                  state_q;
   logic [CW-1:0]           cnt_q;
   logic [NSYN-1:0][7:0]    acc_q;
   logic [NSYN-1:0][7:0]    acc_d;
   logic [NSYN-1:0][7:0]    mul_w;
   logic [8*NSYN-1:0]       syn_q;
   logic                    nonzero_q;
   logic                    accept;
   logic                    last_sym;

   // Valid/ready: a symbol moves when in_valid & in_ready at a rising edge;
   // a result moves when syn_valid & syn_ready. In HOLD, in_ready follows syn_ready
   // so the first symbol of the next word can ride the result handshake.
   assign in_ready    = (state_q == ACCUM) | syn_ready;
   assign accept      = in_valid & in_ready;
   assign last_sym    = (cnt_q == CW'(N - 1));
   assign syn_valid   = (state_q == HOLD);
   assign syn_flat    = syn_q;
   assign syn_nonzero = nonzero_q;

   for (genvar g = 0; g < NSYN; g++) begin : g_syn
      localparam logic [7:0] ROOT = alpha_pow((FCR + g) % 255);

      gf256mul_dec u_mul (
         .a_i (acc_q[g]),
         .b_i (ROOT),
         .p_o (mul_w[g])
      );

      // The first symbol of a word seeds the accumulator, discarding stale contents.
      assign acc_d[g] = (cnt_q == '0) ? in_sym : (mul_w[g] ^ in_sym);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= ACCUM;
         cnt_q     <= '0;
         acc_q     <= '0;
         syn_q     <= '0;
         nonzero_q <= 1'b0;
      end else begin
         if (accept) begin
            acc_q <= acc_d;
            if (last_sym) begin
               cnt_q     <= '0;
               syn_q     <= acc_d;
               nonzero_q <= |acc_d;
               state_q   <= HOLD;
            end else begin
               cnt_q   <= cnt_q + 1'b1;
               state_q <= ACCUM;
            end
         end else if ((state_q == HOLD) && syn_ready) begin
            state_q <= ACCUM;
         end
      end
   end
endmodule
